// File: rtl/uart_rx_defs.sv
// Shared definitions for the UART receive path: register map, receiver
// state encodings and STATUS/CTRL bit positions.
package uart_rx_defs;

    // Register select values, taken from wishbone_addr_i[3:2]
    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_RSVD   = 2'd3;

    // Receiver states; the encoding is visible on rx_state_o
    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_START = 4'd1,
        ST_DATA  = 4'd2,
        ST_STOP  = 4'd3,
        ST_BREAK = 4'd4
    } rx_state_e;

    // STATUS register bit positions
    localparam int STAT_NEMPTY = 0;
    localparam int STAT_FULL   = 1;
    localparam int STAT_FERR   = 2;
    localparam int STAT_OVR    = 3;

    // CTRL register bit positions
    localparam int CTRL_INT_EN = 0;
    localparam int CTRL_CLR    = 1;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous byte FIFO with FIFO_AW+1 bit pointers. Push and pop in the
// same cycle both succeed, including when full; pop on empty is ignored.
module uart_rx_fifo #(
    parameter int FIFO_AW = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);

    logic [7:0]       mem [0:(1 << FIFO_AW) - 1];
    logic [FIFO_AW:0] wr_ptr;
    logic [FIFO_AW:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                     (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr[FIFO_AW-1:0]];

    // Pointer update; pointers wrap naturally through the extra MSB
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset since pointers define validity
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[FIFO_AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_rx_wb.sv
// UART receiver (8N1, LSB first, 16x oversampling) with a byte FIFO and a
// Wishbone slave register file: DATA, STATUS, CTRL.
// Bus handshake: a request is cyc & stb; the slave answers with a one-cycle
// ack one clock later, and all register side effects (pop, CTRL write)
// happen only on the clock edge that raises ack.
module uart_rx_wb
    import uart_rx_defs::*;
#(
    parameter int BAUD_DIV = 27,
    parameter int FIFO_AW  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        com_RxD,
    input  logic        wishbone_cyc_i,
    input  logic        wishbone_stb_i,
    input  logic        wishbone_we_i,
    input  logic [31:0] wishbone_addr_i,
    input  logic [31:0] wishbone_data_i,
    input  logic [15:0] wishbone_select_i,
    output logic [31:0] wishbone_data_o,
    output logic        wishbone_ack_o,
    output logic        rx_int_o,
    output logic [3:0]  rx_state_o
);

    localparam int DIV_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

    logic             rxd_meta, rxd_sync;
    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    rx_state_e        state, state_n;
    logic [3:0]       tick_cnt, tick_n;
    logic [2:0]       bit_cnt, bit_n;
    logic [7:0]       shift, shift_n;
    logic             push, ferr_set;
    logic             overrun, frame_err, int_en;
    logic             acc, pop, ctrl_wr, ovr_set;
    logic [1:0]       reg_sel;
    logic [7:0]       fifo_dout;
    logic             fifo_full, fifo_empty;
    logic [31:0]      rd_data;
    logic             unused_bits;

    assign unused_bits = ^{wishbone_addr_i[31:4], wishbone_addr_i[1:0],
                           wishbone_data_i[31:2], wishbone_select_i[15:1]};

    // Two-flop synchroniser for the asynchronous serial line, idles high
    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
        end else begin
            rxd_meta <= com_RxD;
            rxd_sync <= rxd_meta;
        end
    end

    // Free-running oversample divider; tick pulses on wrap
    assign tick = (div_cnt == DIV_W'(BAUD_DIV - 1));
    always_ff @(posedge clk) begin
        if (rst)       div_cnt <= '0;
        else if (tick) div_cnt <= '0;
        else           div_cnt <= div_cnt + 1'b1;
    end

    // Receiver state, oversample count, bit count and shift register
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
        end else begin
            state    <= state_n;
            tick_cnt <= tick_n;
            bit_cnt  <= bit_n;
            shift    <= shift_n;
        end
    end

    // Next-state logic: start qualified at half a bit, data and stop at bit centres
    always_comb begin
        state_n  = state;
        tick_n   = tick_cnt;
        bit_n    = bit_cnt;
        shift_n  = shift;
        push     = 1'b0;
        ferr_set = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!rxd_sync) begin
                    state_n = ST_START;
                    tick_n  = '0;
                end
            end
            ST_START: begin
                if (tick) begin
                    if (tick_cnt == 4'd7) begin
                        if (!rxd_sync) begin
                            state_n = ST_DATA;
                            tick_n  = '0;
                            bit_n   = '0;
                        end else begin
                            state_n = ST_IDLE;
                        end
                    end else begin
                        tick_n = tick_cnt + 4'd1;
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    tick_n = tick_cnt + 4'd1;
                    if (tick_cnt == 4'd15) begin
                        shift_n = {rxd_sync, shift[7:1]};
                        bit_n   = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state_n = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    tick_n = tick_cnt + 4'd1;
                    if (tick_cnt == 4'd15) begin
                        if (rxd_sync) begin
                            push    = 1'b1;
                            state_n = ST_IDLE;
                        end else begin
                            ferr_set = 1'b1;
                            state_n  = ST_BREAK;
                        end
                    end
                end
            end
            ST_BREAK: begin
                if (rxd_sync) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign rx_state_o = state;

    // Bus decode
    assign acc     = wishbone_cyc_i & wishbone_stb_i & ~wishbone_ack_o;
    assign reg_sel = wishbone_addr_i[3:2];
    assign pop     = acc & ~wishbone_we_i & (reg_sel == REG_DATA) & ~fifo_empty;
    assign ctrl_wr = acc & wishbone_we_i & (reg_sel == REG_CTRL) & wishbone_select_i[0];
    assign ovr_set = push & fifo_full & ~pop;

    uart_rx_fifo #(.FIFO_AW(FIFO_AW)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (shift),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Read mux; DATA on empty reads zero
    always_comb begin
        rd_data = '0;
        case (reg_sel)
            REG_DATA:   rd_data = fifo_empty ? 32'd0 : {24'd0, fifo_dout};
            REG_STATUS: begin
                rd_data[STAT_NEMPTY] = ~fifo_empty;
                rd_data[STAT_FULL]   = fifo_full;
                rd_data[STAT_FERR]   = frame_err;
                rd_data[STAT_OVR]    = overrun;
            end
            REG_CTRL:   rd_data[CTRL_INT_EN] = int_en;
            default:    rd_data = '0;
        endcase
    end

    // Bus response, sticky error flags (set beats clear), interrupt level
    always_ff @(posedge clk) begin
        if (rst) begin
            wishbone_ack_o  <= 1'b0;
            wishbone_data_o <= '0;
            int_en          <= 1'b0;
            overrun         <= 1'b0;
            frame_err       <= 1'b0;
            rx_int_o        <= 1'b0;
        end else begin
            wishbone_ack_o  <= acc;
            wishbone_data_o <= (acc & ~wishbone_we_i) ? rd_data : 32'd0;
            if (ctrl_wr) int_en <= wishbone_data_i[CTRL_INT_EN];
            overrun   <= ovr_set  | (overrun   & ~(ctrl_wr & wishbone_data_i[CTRL_CLR]));
            frame_err <= ferr_set | (frame_err & ~(ctrl_wr & wishbone_data_i[CTRL_CLR]));
            rx_int_o  <= int_en & (~fifo_empty | overrun | frame_err);
        end
    end

endmodule
